// File: rtl/seg7_mux_axil.sv
// AXI4-Lite slave that scans an N-digit common-anode 7-segment display with
// hex decode, decimal points, per-digit blanking, leading-zero blanking and blink.
module seg7_mux_axil #(
    parameter int NUM_DIGITS         = 4,
    parameter int REFRESH_DIV        = 100000,
    parameter int BLINK_FRAMES       = 250,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_TC   = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic                  en_q, blink_q, lzb_q, en_d, blink_d, lzb_d;
    logic [DW-1:0]         data_q, data_d;
    logic [NUM_DIGITS-1:0] dpm_q, dpm_d, blank_q, blank_d;
    logic                  awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [PRE_W-1:0]      pre_q;
    logic [2:0]            idx_q;
    logic [15:0]           frame_q;
    logic [BLK_W-1:0]      bcnt_q;
    logic                  phase_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  wr_fire, rd_fire, tc, off;
    logic [31:0]           data_ext;
    logic [7:0]            dpm_ext, blank_ext;
    logic [4:0]            sh;
    logic [3:0]            nib;
    logic                  unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr, s00_axi_wdata};

    assign wr_fire   = awready_q && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_fire   = arready_q && s00_axi_arvalid;
    assign data_ext  = 32'(data_q);
    assign dpm_ext   = 8'(dpm_q);
    assign blank_ext = 8'(blank_q);

    always_comb begin
        en_d    = en_q;
        blink_d = blink_q;
        lzb_d   = lzb_q;
        data_d  = data_q;
        dpm_d   = dpm_q;
        blank_d = blank_q;
        if (wr_fire) begin
            case (s00_axi_awaddr[3:2])
                2'd0: if (s00_axi_wstrb[0]) begin
                    en_d    = s00_axi_wdata[0];
                    blink_d = s00_axi_wdata[2];
                    lzb_d   = s00_axi_wdata[3];
                end
                2'd1: for (int i = 0; i < DW; i++) begin
                    if (s00_axi_wstrb[i/8]) data_d[i] = s00_axi_wdata[i];
                end
                2'd2: begin
                    if (s00_axi_wstrb[0]) dpm_d   = s00_axi_wdata[NUM_DIGITS-1:0];
                    if (s00_axi_wstrb[1]) blank_d = s00_axi_wdata[8 +: NUM_DIGITS];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (s00_axi_araddr[3:2])
            2'd0:    rdata_d = {28'd0, lzb_q, blink_q, 1'b0, en_q};
            2'd1:    rdata_d = data_ext;
            2'd2:    rdata_d = {16'd0, blank_ext, dpm_ext};
            default: rdata_d = {frame_q, 12'd0, phase_q, idx_q};
        endcase
    end

    // Leading-zero test looks at the current digit and everything above it.
    always_comb begin
        sh    = {idx_q, 2'b00};
        nib   = data_ext[sh +: 4];
        off   = !en_q || blank_ext[idx_q] || (blink_q && phase_q) ||
                (lzb_q && idx_q != 3'd0 && (data_ext >> sh) == 32'd0);
        an_d  = off ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d = off ? 7'h7F : hex7(nib);
        dp_d  = off ? 1'b1 : ~dpm_ext[idx_q];
    end

    assign tc = (pre_q == PRE_TC);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            en_q <= 1'b0;  blink_q <= 1'b0;  lzb_q <= 1'b0;
            data_q <= '0;  dpm_q <= '0;  blank_q <= '0;
            awready_q <= 1'b0;  bvalid_q <= 1'b0;
            arready_q <= 1'b0;  rvalid_q <= 1'b0;  rdata_q <= '0;
            pre_q <= '0;  idx_q <= '0;  frame_q <= '0;  bcnt_q <= '0;  phase_q <= 1'b0;
            an_q <= '1;  seg_q <= 7'h7F;  dp_q <= 1'b1;
        end else begin
            en_q <= en_d;  blink_q <= blink_d;  lzb_q <= lzb_d;
            data_q <= data_d;  dpm_q <= dpm_d;  blank_q <= blank_d;

            awready_q <= !awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q;
            if (wr_fire)             bvalid_q <= 1'b1;
            else if (s00_axi_bready) bvalid_q <= 1'b0;

            arready_q <= !arready_q && s00_axi_arvalid && !rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            if (!en_q) begin
                pre_q <= '0;
                idx_q <= '0;
            end else if (tc) begin
                pre_q <= '0;
                if (idx_q == IDX_LAST) begin
                    idx_q   <= '0;
                    frame_q <= frame_q + 16'd1;
                    if (bcnt_q == BLK_TC) begin
                        bcnt_q  <= '0;
                        phase_q <= !phase_q;
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + 3'd1;
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end

            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_mux_axil.sv
// Directed bench for seg7_mux_axil: display vector table plus blink, AXI and reset sequences.
module tb_seg7_mux_axil;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_mux_axil #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2), .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .an(an), .seg(seg), .dp(dp)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ctrl;
        logic [31:0] mask;
        logic [15:0] an;    // slot k at [4k +: 4]
        logic [27:0] seg;   // slot k at [7k +: 7]
        logic [3:0]  dpv;   // slot k at bit k
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called on a falling edge, returns on a falling edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold);
        int t, bv_low, aw_seen;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
        t = 0;
        while (!(awready && wready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("aw_handshake_in_time", 32'(t < 20), 32'd1);
        @(negedge clk);
        if (hold > 0) begin
            bv_low = 0; aw_seen = 0;
            for (int i = 0; i < hold; i++) begin
                if (!bvalid) bv_low++;
                if (awready) aw_seen++;
                @(negedge clk);
            end
            chk("bvalid_held_low_cycles", 32'(bv_low), 32'd0);
            chk("second_awready_cycles", 32'(aw_seen), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_after_write", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        chk("bvalid_cleared", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ar_handshake_in_time", 32'(t < 20), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_after_read", 32'(rvalid), 32'd1);
        chk("rresp", 32'(rresp), 32'd0);
        data = rdata;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  exp_an;
        int t;

        vecs[0] = '{32'h1234, 32'h1, 32'h0,    16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{32'h0005, 32'h9, 32'h0,    16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF};
        vecs[2] = '{32'h0000, 32'h9, 32'h0,    16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[3] = '{32'h0000, 32'h9, 32'h0201, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hE};
        vecs[4] = '{32'hABCD, 32'h1, 32'h0204, 16'h7BFE, {7'h08, 7'h03, 7'h7F, 7'h21}, 4'hB};
        vecs[5] = '{32'h0F06, 32'h9, 32'h0,    16'hFBDE, {7'h7F, 7'h0E, 7'h40, 7'h02}, 4'hF};
        vecs[6] = '{32'h789E, 32'h1, 32'h0,    16'h7BDE, {7'h78, 7'h00, 7'h10, 7'h06}, 4'hF};
        vecs[7] = '{32'h9C00, 32'h1, 32'h000F, 16'h7BDE, {7'h10, 7'h46, 7'h40, 7'h40}, 4'h0};

        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;
        arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), rd);
            chk($sformatf("rst_read_0x%0h", a * 4), rd, 32'h0);
        end

        // Display vector table
        for (int i = 0; i < 8; i++) begin
            axi_write(4'h0, 32'h0, 4'hF, 0);
            axi_write(4'h4, vecs[i].data, 4'hF, 0);
            axi_write(4'h8, vecs[i].mask, 4'hF, 0);
            axi_write(4'h0, vecs[i].ctrl, 4'hF, 0);
            for (int c = 0; c < 16; c++) begin
                int s;
                s = c / 4;
                chk($sformatf("v%0d_an_c%0d", i, c), 32'(an), 32'(vecs[i].an[4*s +: 4]));
                chk($sformatf("v%0d_seg_c%0d", i, c), 32'(seg), 32'(vecs[i].seg[7*s +: 7]));
                chk($sformatf("v%0d_dp_c%0d", i, c), 32'(dp), 32'(vecs[i].dpv[s]));
                @(negedge clk);
            end
            axi_read(4'hC, rd);
            chk($sformatf("v%0d_status_frame", i), rd & 32'hFFFF0007, 32'(i + 1) << 16);
        end

        // Blink: frames 0-1 lit, 2-3 dark, 4 lit
        do_reset();
        axi_write(4'h4, 32'h1234, 4'hF, 0);
        axi_write(4'h0, 32'h5, 4'hF, 0);
        for (int c = 0; c < 80; c++) begin
            case ((c / 4) % 4)
                0: exp_an = 4'hE;
                1: exp_an = 4'hD;
                2: exp_an = 4'hB;
                default: exp_an = 4'h7;
            endcase
            if (((c / 16) / 2) % 2 == 1) exp_an = 4'hF;
            chk($sformatf("blink_an_c%0d", c), 32'(an), 32'(exp_an));
            @(negedge clk);
        end
        axi_read(4'hC, rd);
        chk("blink_status_f5", rd & 32'hFFFF0008, 32'h0005_0000);
        repeat (16) @(negedge clk);
        axi_read(4'hC, rd);
        chk("blink_status_f6", rd & 32'hFFFF0008, 32'h0006_0008);

        // AXI corner cases
        do_reset();
        axi_write(4'h4, 32'h1234, 4'hF, 10);
        axi_read(4'h4, rd);
        chk("data_after_hold", rd, 32'h1234);
        axi_write(4'h4, 32'hFFFF_FFFF, 4'h1, 0);
        axi_read(4'h4, rd);
        chk("data_wstrb_byte0", rd, 32'h12FF);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(4'hC, rd);
        chk("status_write_ignored", rd, 32'h0);
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(4'h4, rd);
        chk("data_unused_bits", rd, 32'h0000_FFFF);
        axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(4'h8, rd);
        chk("mask_unused_bits", rd, 32'h0000_0F0F);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(4'h0, rd);
        chk("ctrl_unused_bits", rd, 32'h0000_000D);

        // Reset with a read response pending
        axi_write(4'h8, 32'h0, 4'hF, 0);
        axi_write(4'h0, 32'h1, 4'hF, 0);
        repeat (5) @(negedge clk);
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pend_ar_in_time", 32'(t < 20), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("pend_rvalid", 32'(rvalid), 32'd1);
        chk("pend_an_lit", 32'(an != 4'hF), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'h1);
        rst = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        axi_read(4'hC, rd);
        chk("midrst_status", rd, 32'h0);
        axi_read(4'h4, rd);
        chk("midrst_data", rd, 32'h0);
        axi_write(4'h4, 32'h1234, 4'hF, 0);
        axi_write(4'h0, 32'h1, 4'hF, 0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("restart_an_c%0d", c), 32'(an), (c < 4) ? 32'hE : 32'hD);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
